fan_pwm_ctrl: RTL and testbench
===============================

FAN_PWM_CTRL -- requirements
Module: fan_pwm_ctrl

Interface
REQ-001 SHALL have parameter PWM_DIV, default 8, meaning clk cycles per PWM phase step (range 1..65535).
REQ-002 SHALL have parameter RUN_DUTY, default 160, meaning steady-state duty out of 255.
REQ-003 SHALL have parameter KICK_PERIODS, default 250, meaning PWM periods at 100% duty after enable.
REQ-004 SHALL have parameter STALL_PERIODS, default 500, meaning PWM periods without a tach edge that declare a stall.
REQ-005 SHALL have parameter RETRY_PERIODS, default 5000, meaning PWM periods spent in STALL before a restart attempt.
REQ-006 clk  input  1  system clock.
REQ-007 reset_n  input  1  reset, asynchronous, active-low.
REQ-008 fan_en  input  2  per-fan enable, bit i = fan i, from the fans PIO out_port.
REQ-009 fan_tach  input  2  open-collector tach pulses, asynchronous to clk.
REQ-010 fan_pwm  output  2  registered PWM drive, 1 = on.
REQ-011 fan_stall  output  2  registered sticky stall flag per fan.
REQ-012 fan_running  output  2  registered, 1 while the channel is in RUN.

Function
REQ-013 A shared prescaler SHALL count 0..PWM_DIV-1 and emit a one-cycle tick on the terminal count.
REQ-014 A shared 8-bit phase SHALL advance on each tick over 0..254 and wrap to 0; the wrap tick is the period-start pulse (period = 255*PWM_DIV cycles).
REQ-015 Each channel SHALL drive fan_pwm = (phase < duty_q): duty_q 0 is always off, duty_q 255 is always on.
REQ-016 duty_q SHALL load only on the period-start pulse, with one exception: entry to OFF SHALL force fan_pwm to 0 on the next clk edge.
REQ-017 fan_tach SHALL pass through a 2-FF synchronizer; a rising edge is detected on the synchronized signal (latency 3 cycles).
REQ-018 Per-channel states: OFF, KICK, RUN, STALL.
REQ-019 Target duty per state: OFF = 0, KICK = 255, RUN = RUN_DUTY, STALL = 0.
REQ-020 OFF->KICK SHALL occur when fan_en[i]=1; the period counter clears.
REQ-021 KICK->RUN SHALL occur after KICK_PERIODS period-start pulses; the no-tach counter clears.
REQ-022 In KICK and RUN, the no-tach counter SHALL increment per period-start pulse and clear on a tach edge; if both occur in the same cycle, the clear wins.
REQ-023 RUN->STALL SHALL occur when the no-tach counter reaches STALL_PERIODS; fan_stall[i] is set in the same edge.
REQ-024 STALL->KICK SHALL occur after RETRY_PERIODS period-start pulses; fan_stall[i] remains set.
REQ-025 Any state SHALL go to OFF on the next edge when fan_en[i]=0; this has priority over every other transition, and fan_stall[i] clears.
REQ-026 fan_en asserted mid-period SHALL not produce a PWM pulse shorter than one full period at the new duty (follows from REQ-016).
REQ-027 Period counters SHALL be sized ceil(log2(max parameter+1)) and SHALL saturate rather than wrap.
REQ-028 The two channels SHALL be fully independent apart from the shared prescaler and phase.

Reset
REQ-029 On reset_n=0, all outputs, state (OFF), counters, synchronizers, prescaler and phase SHALL go to 0 asynchronously.
REQ-030 Reset release SHALL take effect on the first clk edge with reset_n=1; reset mid-KICK/RUN returns to OFF with no residual stall flag.

Structure
REQ-031 Package fan_ctrl_pkg SHALL hold the state enum and the default parameter constants.
REQ-032 Sub-module fan_channel (state machine, counters, tach sync, duty register) SHALL be instantiated twice; the prescaler and phase live in fan_pwm_ctrl.

Verification (PWM_DIV=2, RUN_DUTY=128, KICK_PERIODS=3, STALL_PERIODS=4, RETRY_PERIODS=8)
REQ-033 Enable fan0 with tach toggling every 100 cycles -> fan_pwm[0] high 510 cycles/period for 3 periods, then high 256 of 510 cycles; fan_running[0]=1; fan1 stays 0.
REQ-034 Enable fan0, tach held low -> fan_stall[0]=1 at the 4th period start after RUN; pwm 0 for 8 periods, then KICK again with stall still 1.
REQ-035 Drop fan_en[0] on the same cycle as the stall threshold -> state OFF, fan_stall[0]=0, pwm 0 next edge.
REQ-036 Tach edge coincident with the period-start pulse at count 3 -> no stall; counter returns to 0.
REQ-037 Assert reset_n=0 mid-RUN for 1 cycle -> all outputs 0 immediately; re-enable restarts in KICK.
REQ-038 Enable both fans 7 cycles apart -> both PWM edges aligned to the shared phase; duty changes only at period start.

Source files
------------

// File: rtl/fan_pwm_ctrl_pkg.sv
// Shared types and default constants for the two-channel fan PWM controller.
package fan_ctrl_pkg;

    localparam int unsigned NUM_FANS              = 2;
    localparam int unsigned PHASE_LAST            = 254;
    localparam int unsigned DEF_PWM_DIV           = 8;
    localparam int unsigned DEF_RUN_DUTY          = 160;
    localparam int unsigned DEF_KICK_PERIODS      = 250;
    localparam int unsigned DEF_STALL_PERIODS     = 500;
    localparam int unsigned DEF_RETRY_PERIODS     = 5000;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_KICK  = 2'd1,
        ST_RUN   = 2'd2,
        ST_STALL = 2'd3
    } fan_state_t;

    function automatic logic [7:0] target_duty(fan_state_t st, logic [7:0] run_duty);
        case (st)
            ST_KICK: return 8'hFF;
            ST_RUN:  return run_duty;
            default: return 8'h00;
        endcase
    endfunction

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fan_pwm_ctrl_if.sv
// Per-fan enable, tach, PWM drive and status bundle.
interface fan_pwm_ctrl_if;
    import fan_ctrl_pkg::*;

    logic [NUM_FANS-1:0] fan_en;
    logic [NUM_FANS-1:0] fan_tach;
    logic [NUM_FANS-1:0] fan_pwm;
    logic [NUM_FANS-1:0] fan_stall;
    logic [NUM_FANS-1:0] fan_running;

    modport master (
        output fan_en,
        output fan_tach,
        input  fan_pwm,
        input  fan_stall,
        input  fan_running
    );

    modport slave (
        input  fan_en,
        input  fan_tach,
        output fan_pwm,
        output fan_stall,
        output fan_running
    );

endinterface

// File: rtl/fan_pwm_ctrl_channel.sv
// One fan channel: kick/run/stall state machine, period counters, tach sync
// and the duty register that only updates at period start.
module fan_channel
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned RUN_DUTY      = DEF_RUN_DUTY,
    parameter int unsigned KICK_PERIODS  = DEF_KICK_PERIODS,
    parameter int unsigned STALL_PERIODS = DEF_STALL_PERIODS,
    parameter int unsigned RETRY_PERIODS = DEF_RETRY_PERIODS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] i_phase,
    input  logic       i_period_start,
    input  logic       i_en,
    input  logic       i_tach,
    output logic       o_pwm,
    output logic       o_stall,
    output logic       o_running
);

    localparam int unsigned PER_MAX = (KICK_PERIODS > RETRY_PERIODS) ? KICK_PERIODS : RETRY_PERIODS;
    localparam int unsigned PW      = cnt_width(PER_MAX);
    localparam int unsigned NW      = cnt_width(STALL_PERIODS);

    fan_state_t     r_state, w_next;
    logic [PW-1:0]  r_per_cnt, w_per_cnt_nxt, w_per_inc;
    logic [NW-1:0]  r_nt_cnt, w_nt_cnt_nxt, w_nt_inc;
    logic           r_tach_s1, r_tach_s2, r_tach_d;
    logic           w_tach_edge;
    logic [7:0]     r_duty;
    logic           r_pwm, r_stall, r_running;

    assign w_tach_edge = r_tach_s2 & ~r_tach_d;
    assign w_per_inc   = (r_per_cnt == PW'(PER_MAX)) ? r_per_cnt : r_per_cnt + 1'b1;
    assign w_nt_inc    = (r_nt_cnt == NW'(STALL_PERIODS)) ? r_nt_cnt : r_nt_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_OFF;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        w_per_cnt_nxt = r_per_cnt;
        w_nt_cnt_nxt  = r_nt_cnt;
        case (r_state)
            ST_OFF: begin
                w_next        = ST_KICK;
                w_per_cnt_nxt = '0;
                w_nt_cnt_nxt  = '0;
            end
            ST_KICK: begin
                if (w_tach_edge)         w_nt_cnt_nxt = '0;
                else if (i_period_start) w_nt_cnt_nxt = w_nt_inc;
                if (i_period_start) begin
                    w_per_cnt_nxt = w_per_inc;
                    if (w_per_inc >= PW'(KICK_PERIODS)) begin
                        w_next       = ST_RUN;
                        w_nt_cnt_nxt = '0;
                    end
                end
            end
            ST_RUN: begin
                // A tach edge in the same cycle as a period start clears and blocks the stall.
                if (w_tach_edge) begin
                    w_nt_cnt_nxt = '0;
                end else if (i_period_start) begin
                    w_nt_cnt_nxt = w_nt_inc;
                    if (w_nt_inc >= NW'(STALL_PERIODS)) begin
                        w_next        = ST_STALL;
                        w_per_cnt_nxt = '0;
                    end
                end
            end
            ST_STALL: begin
                if (i_period_start) begin
                    w_per_cnt_nxt = w_per_inc;
                    if (w_per_inc >= PW'(RETRY_PERIODS)) begin
                        w_next        = ST_KICK;
                        w_per_cnt_nxt = '0;
                        w_nt_cnt_nxt  = '0;
                    end
                end
            end
            default: w_next = ST_OFF;
        endcase
        if (!i_en) begin
            w_next        = ST_OFF;
            w_per_cnt_nxt = '0;
            w_nt_cnt_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_per_cnt <= '0;
            r_nt_cnt  <= '0;
            r_tach_s1 <= 1'b0;
            r_tach_s2 <= 1'b0;
            r_tach_d  <= 1'b0;
            r_duty    <= '0;
            r_pwm     <= 1'b0;
            r_stall   <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_per_cnt <= w_per_cnt_nxt;
            r_nt_cnt  <= w_nt_cnt_nxt;
            r_tach_s1 <= i_tach;
            r_tach_s2 <= r_tach_s1;
            r_tach_d  <= r_tach_s2;
            // Duty is taken from the state at the period start so each period runs whole.
            if (!i_en) begin
                r_duty <= '0;
                r_pwm  <= 1'b0;
            end else begin
                r_pwm <= (i_phase < r_duty);
                if (i_period_start) r_duty <= target_duty(r_state, 8'(RUN_DUTY));
            end
            r_stall   <= i_en && (r_stall || (r_state == ST_RUN && w_next == ST_STALL));
            r_running <= (w_next == ST_RUN);
        end
    end

    assign o_pwm     = r_pwm;
    assign o_stall   = r_stall;
    assign o_running = r_running;

endmodule

// File: rtl/fan_pwm_ctrl.sv
// Two-channel fan controller: shared prescaler and 255-step phase feeding
// two independent fan_channel instances.
module fan_pwm_ctrl
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned PWM_DIV       = DEF_PWM_DIV,
    parameter int unsigned RUN_DUTY      = DEF_RUN_DUTY,
    parameter int unsigned KICK_PERIODS  = DEF_KICK_PERIODS,
    parameter int unsigned STALL_PERIODS = DEF_STALL_PERIODS,
    parameter int unsigned RETRY_PERIODS = DEF_RETRY_PERIODS
) (
    input logic           clk,
    input logic           reset_n,
    fan_pwm_ctrl_if.slave fans
);

    logic [15:0]         r_presc;
    logic [7:0]          r_phase;
    logic                w_tick, w_period_start;
    logic [NUM_FANS-1:0] w_pwm, w_stall, w_running;

    assign w_tick         = (r_presc == 16'(PWM_DIV - 1));
    assign w_period_start = w_tick && (r_phase == 8'(PHASE_LAST));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
            r_phase <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 16'd1;
            if (w_tick) r_phase <= (r_phase == 8'(PHASE_LAST)) ? '0 : r_phase + 8'd1;
        end
    end

    for (genvar g = 0; g < NUM_FANS; g++) begin : g_ch
        fan_channel #(
            .RUN_DUTY      (RUN_DUTY),
            .KICK_PERIODS  (KICK_PERIODS),
            .STALL_PERIODS (STALL_PERIODS),
            .RETRY_PERIODS (RETRY_PERIODS)
        ) u_ch (
            .clk            (clk),
            .reset_n        (reset_n),
            .i_phase        (r_phase),
            .i_period_start (w_period_start),
            .i_en           (fans.fan_en[g]),
            .i_tach         (fans.fan_tach[g]),
            .o_pwm          (w_pwm[g]),
            .o_stall        (w_stall[g]),
            .o_running      (w_running[g])
        );
    end

    assign fans.fan_pwm     = w_pwm;
    assign fans.fan_stall   = w_stall;
    assign fans.fan_running = w_running;

endmodule

// File: tb/tb_fan_pwm_ctrl.sv
// Directed bench for fan_pwm_ctrl with a cycle-count based reference model.
module tb_fan_pwm_ctrl;

    localparam int DIV    = 2;
    localparam int RDUTY  = 128;
    localparam int KICK   = 3;
    localparam int STALLP = 4;
    localparam int RETRY  = 8;
    localparam int PER    = 255 * DIV;
    localparam int M_OFF = 0, M_KICK = 1, M_RUN = 2, M_STALL = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    fan_pwm_ctrl_if u_if();

    fan_pwm_ctrl #(
        .PWM_DIV       (DIV),
        .RUN_DUTY      (RDUTY),
        .KICK_PERIODS  (KICK),
        .STALL_PERIODS (STALLP),
        .RETRY_PERIODS (RETRY)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .fans    (u_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_edges  = 0;
    int m_mode[2], m_duty[2], m_per[2], m_nt[2];
    bit m_pwm[2], m_stall[2], m_run[2];
    bit t_hist[2][3];
    int hi0[20], hi1[20];
    int ndiff = 0;
    bit diff_en = 0;
    bit tog_en[2];
    int tog_cnt[2];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, n_edges);
        end
    endtask

    function automatic int duty_of(input int mode);
        case (mode)
            M_KICK:  return 255;
            M_RUN:   return RDUTY;
            default: return 0;
        endcase
    endfunction

    // Model advances once per clock edge (inputs are still what that edge sampled), then compares.
    always @(negedge clk) begin
        if (!reset_n) begin
            n_edges = 0;
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = M_OFF; m_duty[i] = 0; m_per[i] = 0; m_nt[i] = 0;
                m_pwm[i] = 0; m_stall[i] = 0; m_run[i] = 0;
                for (int k = 0; k < 3; k++) t_hist[i][k] = 0;
            end
        end else begin
            int phb;
            bit pulse;
            n_edges++;
            pulse = (n_edges % PER) == 0;
            phb   = ((n_edges - 1) / DIV) % 255;
            for (int i = 0; i < 2; i++) begin
                bit tedge;
                tedge = t_hist[i][1] && !t_hist[i][2];
                t_hist[i][2] = t_hist[i][1];
                t_hist[i][1] = t_hist[i][0];
                t_hist[i][0] = u_if.fan_tach[i];
                if (!u_if.fan_en[i]) begin
                    m_mode[i] = M_OFF; m_duty[i] = 0; m_pwm[i] = 0;
                    m_stall[i] = 0; m_per[i] = 0; m_nt[i] = 0;
                end else begin
                    m_pwm[i] = (phb < m_duty[i]);
                    if (pulse) m_duty[i] = duty_of(m_mode[i]);
                    case (m_mode[i])
                        M_OFF: begin
                            m_mode[i] = M_KICK; m_per[i] = 0; m_nt[i] = 0;
                        end
                        M_KICK: begin
                            if (pulse) m_per[i]++;
                            if (tedge) m_nt[i] = 0; else if (pulse) m_nt[i]++;
                            if (m_per[i] >= KICK) begin m_mode[i] = M_RUN; m_nt[i] = 0; end
                        end
                        M_RUN: begin
                            if (tedge) m_nt[i] = 0; else if (pulse) m_nt[i]++;
                            if (m_nt[i] >= STALLP) begin
                                m_mode[i] = M_STALL; m_stall[i] = 1; m_per[i] = 0;
                            end
                        end
                        default: begin
                            if (pulse) m_per[i]++;
                            if (m_per[i] >= RETRY) begin
                                m_mode[i] = M_KICK; m_per[i] = 0; m_nt[i] = 0;
                            end
                        end
                    endcase
                end
                m_run[i] = (m_mode[i] == M_RUN);
                check($sformatf("pwm[%0d]", i),     int'(u_if.fan_pwm[i]),     int'(m_pwm[i]));
                check($sformatf("stall[%0d]", i),   int'(u_if.fan_stall[i]),   int'(m_stall[i]));
                check($sformatf("running[%0d]", i), int'(u_if.fan_running[i]), int'(m_run[i]));
            end
            if ((n_edges - 1) / PER < 20) begin
                hi0[(n_edges - 1) / PER] += int'(u_if.fan_pwm[0]);
                hi1[(n_edges - 1) / PER] += int'(u_if.fan_pwm[1]);
            end
            if (diff_en && (u_if.fan_pwm[0] != u_if.fan_pwm[1])) ndiff++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (tog_en[i]) begin
                tog_cnt[i]++;
                if (tog_cnt[i] == 100) begin
                    u_if.fan_tach[i] = ~u_if.fan_tach[i];
                    tog_cnt[i] = 0;
                end
            end
        end
    endtask

    task automatic wait_edge(input int m);
        int guard = 0;
        while (n_edges < m && guard < 20000) begin
            step();
            guard++;
        end
        check("edge_sync", n_edges, m);
    endtask

    task automatic clear_hist();
        for (int w = 0; w < 20; w++) begin hi0[w] = 0; hi1[w] = 0; end
        ndiff = 0;
        diff_en = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        u_if.fan_en = 2'b00;
        u_if.fan_tach = 2'b00;
        for (int i = 0; i < 2; i++) begin tog_en[i] = 0; tog_cnt[i] = 0; end
        repeat (3) @(negedge clk);
        #1;
        check("rst_pwm",     int'(u_if.fan_pwm),     0);
        check("rst_stall",   int'(u_if.fan_stall),   0);
        check("rst_running", int'(u_if.fan_running), 0);
        clear_hist();
        reset_n = 1'b1;
    endtask

    initial begin
        u_if.fan_en = 2'b00;
        u_if.fan_tach = 2'b00;

        // Kick for three full periods, then steady run duty.
        do_reset();
        tog_en[0] = 1;
        wait_edge(19);
        u_if.fan_en[0] = 1'b1;
        wait_edge(3060);
        check("s1_win0", hi0[0], 0);
        check("s1_win1", hi0[1], 510);
        check("s1_win2", hi0[2], 510);
        check("s1_win3", hi0[3], 510);
        check("s1_win4", hi0[4], 256);
        check("s1_win5", hi0[5], 256);
        check("s1_run0", int'(u_if.fan_running[0]), 1);
        check("s1_fan1", hi1[0] + hi1[1] + hi1[2] + hi1[3] + hi1[4] + hi1[5], 0);

        // No tach: stall at the 4th period start in RUN, 8 dead periods, then kick again.
        do_reset();
        wait_edge(19);
        u_if.fan_en[0] = 1'b1;
        wait_edge(3569);
        check("s2_prestall", int'(u_if.fan_stall[0]), 0);
        wait_edge(3570);
        check("s2_stall", int'(u_if.fan_stall[0]), 1);
        wait_edge(8700);
        check("s2_win7", hi0[7], 256);
        check("s2_dead", hi0[8] + hi0[9] + hi0[10] + hi0[11] + hi0[12] + hi0[13] + hi0[14] + hi0[15], 0);
        check("s2_rekick", hi0[16], 510);
        check("s2_sticky", int'(u_if.fan_stall[0]), 1);
        check("s2_pwm_on", int'(u_if.fan_pwm[0]), 1);
        u_if.fan_en[0] = 1'b0;
        wait_edge(8701);
        check("s2_off_pwm", int'(u_if.fan_pwm[0]), 0);
        check("s2_off_stall", int'(u_if.fan_stall[0]), 0);

        // Disable on the exact stall-threshold edge.
        do_reset();
        wait_edge(19);
        u_if.fan_en[0] = 1'b1;
        wait_edge(3569);
        check("s3_running", int'(u_if.fan_running[0]), 1);
        u_if.fan_en[0] = 1'b0;
        wait_edge(3570);
        check("s3_stall", int'(u_if.fan_stall[0]), 0);
        check("s3_pwm", int'(u_if.fan_pwm[0]), 0);
        check("s3_running_off", int'(u_if.fan_running[0]), 0);

        // Tach edge lands on the period start that would have stalled.
        do_reset();
        wait_edge(19);
        u_if.fan_en[0] = 1'b1;
        wait_edge(3567);
        u_if.fan_tach[0] = 1'b1;
        wait_edge(3570);
        check("s4_nostall", int'(u_if.fan_stall[0]), 0);
        check("s4_running", int'(u_if.fan_running[0]), 1);
        wait_edge(5609);
        check("s4_late_pre", int'(u_if.fan_stall[0]), 0);
        wait_edge(5610);
        check("s4_late_stall", int'(u_if.fan_stall[0]), 1);

        // Asynchronous reset mid-RUN.
        do_reset();
        tog_en[0] = 1;
        wait_edge(19);
        u_if.fan_en[0] = 1'b1;
        wait_edge(2100);
        check("s5_pre_pwm", int'(u_if.fan_pwm[0]), 1);
        check("s5_pre_run", int'(u_if.fan_running[0]), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("s5_rst_pwm",     int'(u_if.fan_pwm),     0);
        check("s5_rst_stall",   int'(u_if.fan_stall),   0);
        check("s5_rst_running", int'(u_if.fan_running), 0);
        clear_hist();
        @(negedge clk);
        #3;
        reset_n = 1'b1;
        wait_edge(1020);
        check("s5_win0", hi0[0], 0);
        check("s5_win1", hi0[1], 510);
        check("s5_kick", int'(u_if.fan_running[0]), 0);

        // Both fans, enables seven cycles apart, stay phase aligned.
        do_reset();
        tog_en[0] = 1;
        tog_en[1] = 1;
        wait_edge(19);
        u_if.fan_en[0] = 1'b1;
        wait_edge(26);
        u_if.fan_en[1] = 1'b1;
        wait_edge(27);
        diff_en = 1;
        wait_edge(3060);
        check("s6_win0", hi1[0], 0);
        check("s6_win1", hi1[1], 510);
        check("s6_win3", hi1[3], 510);
        check("s6_win4", hi1[4], 256);
        check("s6_win5", hi1[5], 256);
        check("s6_aligned", ndiff, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
